// File: rtl/jp_scanner.sv
// Serial joypad scanner: latches/clocks NUM_PADS pads in parallel, commits state, CPU strobe/serial read port.
// Scan takes (2*PAD_BITS-1)*CLK_DIV+1 cycles; rd_d_out is one cycle after rd_en_in.
// No backpressure. `define JP_CHANGE_DET_EN adds change_out pulses on a changed commit.
module jp_scanner #(
   parameter int NUM_PADS    = 2,
   parameter int PAD_BITS    = 8,
   parameter int CLK_DIV     = 600,
   parameter int SCAN_PERIOD = 1666667
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_PADS-1:0]          jp_data_in,
   input  logic                         scan_req_in,
   input  logic                         strobe_wr_in,
   input  logic                         strobe_d_in,
   input  logic                         rd_en_in,
   input  logic [1:0]                   rd_sel_in,
   output logic                         jp_clk,
   output logic                         jp_latch,
   output logic [NUM_PADS*PAD_BITS-1:0] pad_state_out,
   output logic                         valid_out,
   output logic                         busy_out,
   output logic                         rd_d_out,
   output logic                         change_out
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(PAD_BITS + 1);
   localparam int IW = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
   localparam int PW = $clog2(SCAN_PERIOD + 1);

   typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;
   state_t state, state_nx;

   logic [DW-1:0]             div_cnt;
   logic [BW-1:0]             bit_cnt;
   logic [PW-1:0]             per_cnt;
   logic [NUM_PADS-1:0]       sync1, sync2, pressed;
   logic [PAD_BITS-1:0]       shreg [NUM_PADS];
   logic [PAD_BITS-1:0]       snap  [NUM_PADS];
   logic [BW-1:0]             ptr   [NUM_PADS];
   logic                      strobe;
   logic [PAD_BITS-1:0]       cap_pad;
   logic [NUM_PADS*PAD_BITS-1:0] cap_flat;
   logic                      div_last, sample, commit, strobe_clr;
   logic                      sel_ok, sel_live, sel_sat, sel_snap;
   logic [IW-1:0]             bit_idx;

   assign pressed    = ~sync2;
   assign div_last   = (div_cnt == DW'(CLK_DIV - 1));
   assign sample     = div_last && (state == LATCH || state == CLK_HI);
   assign commit     = sample && (bit_cnt == BW'(PAD_BITS - 1));
   assign bit_idx    = bit_cnt[IW-1:0];
   assign busy_out   = (state != IDLE);
   assign strobe_clr = strobe_wr_in && strobe && !strobe_d_in;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (scan_req_in || per_cnt == PW'(SCAN_PERIOD - 1)) state_nx = LATCH;
         LATCH:   if (div_last) state_nx = (PAD_BITS == 1) ? DONE : CLK_LO;
         CLK_LO:  if (div_last) state_nx = CLK_HI;
         CLK_HI:  if (div_last) state_nx = commit ? DONE : CLK_LO;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Shift contents with the bit being sampled this cycle already merged in.
   always_comb begin
      cap_pad  = '0;
      cap_flat = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         cap_pad          = shreg[i];
         cap_pad[bit_idx] = pressed[i];
         cap_flat[i*PAD_BITS +: PAD_BITS] = cap_pad;
      end
   end

   always_comb begin
      sel_ok   = 1'b0;
      sel_live = 1'b0;
      sel_sat  = 1'b0;
      sel_snap = 1'b0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (rd_sel_in == 2'(i)) begin
            sel_ok   = 1'b1;
            sel_live = pad_state_out[i*PAD_BITS];
            sel_sat  = (ptr[i] == BW'(PAD_BITS));
            sel_snap = snap[i][ptr[i][IW-1:0]];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= IDLE;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         per_cnt       <= '0;
         sync1         <= '0;
         sync2         <= '0;
         jp_clk        <= 1'b0;
         jp_latch      <= 1'b0;
         pad_state_out <= '0;
         valid_out     <= 1'b0;
         strobe        <= 1'b0;
         rd_d_out      <= 1'b0;
         for (int i = 0; i < NUM_PADS; i++) begin
            shreg[i] <= '0;
            snap[i]  <= '0;
            ptr[i]   <= '0;
         end
      end else begin
         state     <= state_nx;
         sync1     <= jp_data_in;
         sync2     <= sync1;
         jp_latch  <= (state_nx == LATCH);
         jp_clk    <= (state_nx == CLK_HI);
         valid_out <= commit;
         div_cnt   <= (state == IDLE || state == DONE || div_last) ? '0 : div_cnt + 1'b1;
         per_cnt   <= (state == DONE) ? '0 : (state == IDLE) ? per_cnt + 1'b1 : per_cnt;
         if (state == IDLE)
            bit_cnt <= '0;
         else if (sample)
            bit_cnt <= bit_cnt + 1'b1;
         for (int i = 0; i < NUM_PADS; i++) begin
            if (sample)
               shreg[i][bit_idx] <= pressed[i];
         end
         if (commit)
            pad_state_out <= cap_flat;

         // Reads see pre-write strobe and the pre-commit pad state.
         if (rd_en_in) begin
            if (!sel_ok)
               rd_d_out <= 1'b0;
            else if (strobe)
               rd_d_out <= sel_live;
            else
               rd_d_out <= sel_sat ? 1'b1 : sel_snap;
         end
         for (int i = 0; i < NUM_PADS; i++) begin
            if (strobe_clr) begin
               snap[i] <= pad_state_out[i*PAD_BITS +: PAD_BITS];
               ptr[i]  <= '0;
            end else if (rd_en_in && !strobe && rd_sel_in == 2'(i) && ptr[i] != BW'(PAD_BITS)) begin
               ptr[i] <= ptr[i] + 1'b1;
            end
         end
         if (strobe_wr_in)
            strobe <= strobe_d_in;
      end
   end

`ifdef JP_CHANGE_DET_EN
   always_ff @(posedge clk_in) begin
      if (rst_in)
         change_out <= 1'b0;
      else
         change_out <= commit && (cap_flat != pad_state_out);
   end
`else
   assign change_out = 1'b0;
`endif

endmodule
